// File: rtl/hex_entry_pkg.sv
// Shared types and constants for the hex digit entry block: FSM state
// encodings, word geometry and the leading-digit blank mask helper.
package hex_entry_pkg;

  localparam int NDIG   = 8;
  localparam int WORD_W = 32;
  localparam int CNT_W  = 4;

  localparam logic [CNT_W-1:0] CNT_ZERO = 4'd0;
  localparam logic [CNT_W-1:0] CNT_FULL = 4'd8;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ENTRY = 2'd1,
    FULL  = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Positions at or above the digit count are blank; an empty entry keeps
  // the lowest position lit so a single "0" is shown.
  function automatic logic [NDIG-1:0] blank_mask(input logic [CNT_W-1:0] n);
    logic [NDIG-1:0] m;
    m = 8'h00;
    if (n == CNT_ZERO) begin
      m = 8'hFE;
    end else begin
      for (int i = 0; i < NDIG; i++) begin
        m[i] = (CNT_W'(i) >= n);
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/edge_rise.sv
// Registered rising-edge detector: one pulse per low-to-high transition.
// Levels are treated as previously low out of reset.
module edge_rise #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] lvl_i,
  output logic [W-1:0] rise_o
);

  logic [W-1:0] prev_q;
  logic [W-1:0] rise_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q <= {W{1'b0}};
      rise_q <= {W{1'b0}};
    end else begin
      prev_q <= lvl_i;
      rise_q <= lvl_i & ~prev_q;
    end
  end

  assign rise_o = rise_q;

endmodule

// File: rtl/hex_entry.sv
// Hex keypad entry: shifts digits into a 32-bit word with backspace, clear
// and commit. Define HEX_ENTRY_BLANK_EN to build the leading-digit blank mask.
module hex_entry
  import hex_entry_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        digit,
  input  logic              key,
  input  logic              bksp,
  input  logic              clr,
  input  logic              commit,
  output logic [WORD_W-1:0] Hexs,
  output logic [CNT_W-1:0]  cnt,
  output logic              full,
  output logic              ovf,
  output logic [WORD_W-1:0] value,
  output logic              value_valid,
  output logic [NDIG-1:0]   blank
);

  logic [3:0] rise;
  logic       key_e, bksp_e, clr_e, commit_e;

  edge_rise #(.W(4)) u_edge (
    .clk    (clk),
    .rst    (rst),
    .lvl_i  ({commit, clr, bksp, key}),
    .rise_o (rise)
  );

  assign {commit_e, clr_e, bksp_e, key_e} = rise;

  state_e             state_q, state_d;
  logic [WORD_W-1:0]  hexs_q, hexs_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               full_q, ovf_q, ovf_d;
  logic [WORD_W-1:0]  value_q, value_d;
  logic               valid_q, valid_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      hexs_q  <= 32'h0;
      cnt_q   <= 4'd0;
      full_q  <= 1'b0;
      ovf_q   <= 1'b0;
      value_q <= 32'h0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hexs_q  <= hexs_d;
      cnt_q   <= cnt_d;
      full_q  <= (cnt_d == CNT_FULL);
      ovf_q   <= ovf_d;
      value_q <= value_d;
      valid_q <= valid_d;
    end
  end

  // Edge priority is clr > commit > bksp > key; DONE swallows all edges.
  always_comb begin
    state_d = state_q;
    hexs_d  = hexs_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    value_d = value_q;
    valid_d = 1'b0;
    case (state_q)
      DONE: begin
        state_d = EMPTY;
        hexs_d  = 32'h0;
        cnt_d   = 4'd0;
        ovf_d   = 1'b0;
      end
      default: begin
        if (clr_e) begin
          state_d = EMPTY;
          hexs_d  = 32'h0;
          cnt_d   = 4'd0;
          ovf_d   = 1'b0;
        end else if (commit_e) begin
          state_d = DONE;
          value_d = hexs_q;
          valid_d = 1'b1;
        end else if (bksp_e) begin
          if (state_q != EMPTY) begin
            hexs_d  = {4'h0, hexs_q[WORD_W-1:4]};
            cnt_d   = cnt_q - 4'd1;
            state_d = (cnt_d == CNT_ZERO) ? EMPTY : ENTRY;
          end else begin
            state_d = EMPTY;
          end
        end else if (key_e) begin
          if (state_q == FULL) begin
            ovf_d = 1'b1;
          end else begin
            hexs_d  = {hexs_q[WORD_W-5:0], digit};
            cnt_d   = cnt_q + 4'd1;
            state_d = (cnt_d == CNT_FULL) ? FULL : ENTRY;
          end
        end else begin
          state_d = state_q;
        end
      end
    endcase
  end

`ifdef HEX_ENTRY_BLANK_EN
  logic [NDIG-1:0] blank_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      blank_q <= 8'hFE;
    end else begin
      blank_q <= blank_mask(cnt_d);
    end
  end

  assign blank = blank_q;
`else
  assign blank = 8'h00;
`endif

  assign Hexs        = hexs_q;
  assign cnt         = cnt_q;
  assign full        = full_q;
  assign ovf         = ovf_q;
  assign value       = value_q;
  assign value_valid = valid_q;

endmodule

// File: doc/hex_entry.md
# hex_entry

Collects hexadecimal digits typed one at a time (debounced buttons or switches) and assembles them into a 32-bit word, shifting each new nibble in at the least-significant end. Hexs[31:0] is the working word and feeds the existing 8-digit display splitter. commit latches the word into a held result with a one-cycle valid pulse. The block sits between the board input debouncers and the datapath/display in the top level.

## Interface
- NDIG, 8: digit capacity. The word is 4*NDIG bits. The only supported value is 8.
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- digit  in  4  hex value of the key being entered.
- key  in  1  debounced level; its rising edge enters `digit`.
- bksp  in  1  debounced level; its rising edge deletes the last digit.
- clr  in  1  debounced level; its rising edge clears the entry.
- commit  in  1  debounced level; its rising edge latches the entry.
- Hexs  out  32  working word; the newest digit is in Hexs[3:0].
- cnt  out  4  number of digits entered, 0..8.
- full  out  1  high when cnt==8.
- ovf  out  1  sticky; set when a digit arrives while full.
- value  out  32  last committed word.
- value_valid  out  1  one-cycle pulse when `value` updates.
- blank  out  8  per-digit blank mask. See Configuration.

## Operation
- Edge detection: a registered rising-edge detector on each of key, bksp, clr and commit gives one pulse per press. Holding a level produces no repeat.
- Priority when edges coincide in the same cycle: clr > commit > bksp > key. Only the highest-priority edge acts; the others are dropped.
- FSM states and transitions:
  - EMPTY (cnt==0): key → ENTRY; commit → DONE; bksp → no-op.
  - ENTRY (1..7 digits): key → ENTRY, or FULL when cnt reaches 8; bksp → ENTRY, or EMPTY when cnt reaches 0.
  - FULL (cnt==8): key is ignored and sets ovf; bksp → ENTRY.
  - DONE: lasts exactly one cycle, then → EMPTY. Any edge arriving in DONE is dropped.
  - From every state: clr → EMPTY; commit → DONE.
- key: Hexs ← {Hexs[27:0], digit}; cnt+1.
- bksp: Hexs ← {4'h0, Hexs[31:4]}; cnt−1. No underflow: in EMPTY it does nothing.
- clr: Hexs ← 0, cnt ← 0, ovf ← 0. `value` is unchanged.
- commit: value ← Hexs and value_valid=1, both during the DONE cycle. Then Hexs ← 0, cnt ← 0, ovf ← 0 when entering EMPTY. Committing in EMPTY commits 32'h0.
- No wrap-around: Hexs never loses the top digit. Overflowing digits are discarded.

## Timing
- Reset values: Hexs=0, cnt=0, full=0, ovf=0, value=0, value_valid=0, state EMPTY, edge registers=0. All levels are treated as previously low, so an input held high through reset yields one edge after reset releases.
- Latency: input level rise at cycle N → edge pulse at N+1 → Hexs/cnt updated visible at N+2.
- commit rise at N → value and value_valid visible at N+2 → Hexs=0 at N+3.
- Reset mid-operation overrides every input in that cycle. A commit in flight is lost and value_valid does not pulse.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- HEX_ENTRY_BLANK_EN defined: blank[i]=1 for every i ≥ cnt, so unentered leading positions can be blanked by the display driver. In EMPTY, blank=8'hFE so a single "0" shows. blank is registered and updates in the same cycle as cnt.
- Not defined: blank is tied to 8'h00 and no blanking logic is built.

## Structure
- A shared package/header hex_entry_pkg holds:
  - state encodings EMPTY=2'd0, ENTRY=2'd1, FULL=2'd2, DONE=2'd3;
  - localparams NDIG=8 and WORD_W=32.
- One sub-module, edge_rise: a parameterized-width registered rising-edge detector with a synchronous, active-high reset. It is instantiated once with width 4 for key/bksp/clr/commit.

## Test plan
- Digit entry: after reset, enter 1,2,3 → Hexs=32'h00000123, cnt=3, full=0, blank=8'hF8 with HEX_ENTRY_BLANK_EN defined.
- Overflow: enter 1..8 then 9 → Hexs=32'h12345678, full=1, ovf=1; bksp → Hexs=32'h01234567, cnt=7, full=0, ovf still 1.
- Commit: from 32'h0000ABCD, commit → value=32'h0000ABCD with value_valid high exactly one cycle; next cycle Hexs=0, cnt=0, ovf=0.
- Simultaneous edges: clr+key on the same cycle from 32'h00000012 → Hexs=0, cnt=0. commit+bksp → value=32'h00000012, no backspace.
- Empty and held inputs: bksp in EMPTY → no change. key held high for 50 cycles → exactly one digit entered.
- Reset mid-commit: rst asserted in the DONE cycle → value_valid=0 next cycle; all outputs at reset values (value=0).
